// File: rtl/riscvibe_pkg.sv
// riscvibe_pkg: shared types and defaults for the riscvibe core.
// Contents:
//   arb_state_t               - memory port arbiter FSM states
//   owner_t                   - which pipeline stage owns the bus transaction
//   MEM_ARB_MAX_WAIT_DEFAULT  - default timeout window of the memory port arbiter
package riscvibe_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  localparam int unsigned MEM_ARB_MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory bus between instruction fetch (IF)
// and load/store (MEM). One transaction in flight at a time; the response goes
// back to the stage that issued it.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   if_req/if_addr             - fetch request (held until if_rvalid)
//   if_rvalid/if_rdata         - fetch response, one-cycle pulse
//   if_stall                   - fetch waiting (combinational)
//   mem_req/we/be/addr/wdata   - load/store request (held until mem_rvalid)
//   mem_rvalid/mem_rdata       - load data / store done, one-cycle pulse
//   mem_stall                  - MEM stage waiting (combinational)
//   flush_if                   - branch taken; kill current/pending fetch
//   bus_req/we/be/addr/wdata   - registered bus request, held until bus_gnt
//   bus_gnt, bus_rvalid/rdata  - bus accept and response
//   bus_timeout                - sticky flag: a transaction was aborted by timeout
module mem_port_arbiter
  import riscvibe_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = MEM_ARB_MAX_WAIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  input  logic                flush_if,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_timeout
);

  localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  arb_state_t      state_q;
  owner_t          owner_q;
  owner_t          last_owner_q;
  logic            kill_q;
  logic [CntW-1:0] cnt_q;

  logic            if_cand;
  logic            sel_mem;
  logic            kill_now;
  logic            busy;
  logic            done_bus;
  logic            done_to;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    if_cand  = if_req && !flush_if;
    // On a tie MEM wins unless it had the previous transaction.
    sel_mem  = mem_req && (!if_cand || (last_owner_q == OWN_IF));
    // A flush landing on the completion cycle still kills the fetch.
    kill_now = kill_q || (flush_if && (owner_q == OWN_IF));
    busy     = (state_q == ARB_REQ) || (state_q == ARB_WAIT);
    done_bus = ((state_q == ARB_REQ) && bus_gnt && bus_rvalid) ||
               ((state_q == ARB_WAIT) && bus_rvalid);
    done_to  = busy && !done_bus && (cnt_q == CntLast);
    resp_data = done_bus ? bus_rdata : '0;
    if_stall  = if_req && !if_rvalid && !flush_if;
    mem_stall = mem_req && !mem_rvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_be       <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      mem_rvalid   <= 1'b0;
      mem_rdata    <= '0;
      bus_timeout  <= 1'b0;
    end else begin
      if_rvalid  <= 1'b0;
      mem_rvalid <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          cnt_q  <= '0;
          kill_q <= 1'b0;
          if (mem_req || if_cand) begin
            state_q <= ARB_REQ;
            bus_req <= 1'b1;
            if (sel_mem) begin
              owner_q   <= OWN_MEM;
              bus_we    <= mem_we;
              bus_be    <= mem_be;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
            end else begin
              owner_q   <= OWN_IF;
              bus_we    <= 1'b0;
              bus_be    <= '1;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
            end
          end
        end
        ARB_REQ, ARB_WAIT: begin
          if (done_bus || done_to) begin
            state_q      <= ARB_IDLE;
            bus_req      <= 1'b0;
            last_owner_q <= owner_q;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            if (done_to) begin
              bus_timeout <= 1'b1;
            end
            if (owner_q == OWN_MEM) begin
              mem_rvalid <= 1'b1;
              mem_rdata  <= resp_data;
            end else if (!kill_now) begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (flush_if && (owner_q == OWN_IF)) begin
              kill_q <= 1'b1;
            end
            if ((state_q == ARB_REQ) && bus_gnt) begin
              state_q <= ARB_WAIT;
              bus_req <= 1'b0;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Issues one bus transaction at a time and tracks its owner.
- Returns the response to the correct stage and produces per-stage stall signals, which top-level pipeline control ORs with the load-use stalls.
- Drops the response of any fetch killed by a branch flush, and times out hung bus transactions.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 255, cycles in ARB_REQ+ARB_WAIT before timeout abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request, held until if_rvalid
if_addr  in  ADDR_W  fetch address
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch data
if_stall  out  1  fetch waiting
mem_req  in  1  load/store request, held until mem_rvalid
mem_we  in  1  1=store
mem_be  in  DATA_W/8  byte enables
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rvalid  out  1  load data valid / store done, one-cycle pulse
mem_rdata  out  DATA_W  load data
mem_stall  out  1  MEM stage waiting
flush_if  in  1  branch taken; kill current/pending fetch
bus_req  out  1  bus request, held until bus_gnt
bus_we  out  1  write
bus_be  out  DATA_W/8  byte enables
bus_addr  out  ADDR_W  address
bus_wdata  out  DATA_W  write data
bus_gnt  in  1  request accepted
bus_rvalid  in  1  response (reads and writes)
bus_rdata  in  DATA_W  read data
bus_timeout  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State ARB_IDLE.
  - All outputs 0, including bus_timeout.
  - Wait counter 0, kill flag 0, last_owner=OWN_IF (so MEM wins the first tie).
- ARB_IDLE selection:
  - mem_req alone -> MEM.
  - if_req && !flush_if alone -> IF.
  - Both -> MEM, unless last_owner==OWN_MEM, then IF (alternation prevents starvation).
  - Winner's fields are registered onto bus_*. Owner is latched. Next state ARB_REQ.
  - IF store fields: bus_we=0, bus_be=all ones.
- ARB_REQ:
  - bus_req=1; bus_* held stable.
  - On bus_gnt: bus_req drops next cycle.
  - If bus_rvalid is also asserted in the same cycle -> complete. Otherwise -> ARB_WAIT.
- ARB_WAIT: on bus_rvalid -> complete.
- Completion:
  - Registered: owner's *_rvalid=1 and *_rdata=bus_rdata on the following cycle.
  - last_owner updated; return to ARB_IDLE.
  - A killed IF completion produces no if_rvalid; the data is discarded.
- Minimum latency, request seen in IDLE at cycle 0:
  - bus_req at cycle 1.
  - With gnt+rvalid at cycle 1, *_rvalid at cycle 2.
  - A new arbitration is possible at cycle 2.
- Stall outputs (combinational):
  - if_stall = if_req && !if_rvalid && !flush_if.
  - mem_stall = mem_req && !mem_rvalid.
- Flush:
  - flush_if while owner==IF in ARB_REQ/ARB_WAIT sets the kill flag.
  - A bus transaction already requested is never withdrawn; it completes on the bus and is silently dropped.
  - The kill flag clears on completion.
  - flush_if in ARB_IDLE blocks IF selection that cycle only.
  - flush_if has no effect on a MEM-owned transaction.
- Timeout:
  - The counter increments each cycle in ARB_REQ/ARB_WAIT and clears in ARB_IDLE.
  - When it reaches MAX_WAIT-1 without completion:
    - Force completion: owner's rvalid with rdata=0, unless killed.
    - bus_req dropped; bus_timeout set (sticky until rst); return to ARB_IDLE.
  - A late bus_rvalid arriving in ARB_IDLE is ignored.
- Requesters must hold req and fields stable until rvalid. Changes mid-transaction are ignored; the latched fields are used.
- rst mid-transaction returns to reset values immediately. The bus master above is reset together with this block.

Decomposition:
- riscvibe_pkg gains:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - typedef enum logic owner_t {OWN_IF, OWN_MEM}
  - localparam MEM_ARB_MAX_WAIT_DEFAULT = 255
- Single module; no natural sub-module. The counter and FSM are inline.

Test Plan:
- Lone fetch:
  - Stimulus: if_req=1 with if_addr=0x100; bus_gnt=1 at cycle 1; bus_rvalid=1 at cycle 3 with rdata=0x00500093.
  - Response: bus_addr=0x100 and bus_we=0 at cycle 1; if_rvalid=1 and if_rdata=0x00500093 at cycle 4; if_stall=1 on cycles 0-3.
- Tie:
  - Stimulus: if_req and mem_req (load 0x2000) both asserted at cycle 0 after reset.
  - Response: MEM served first. Then IF served next without waiting on a new mem_req, because of alternation. mem_stall is 0 after mem_rvalid.
- Store:
  - Stimulus: mem_we=1, mem_be=4'b0011, addr=0x2004, wdata=0xDEADBEEF; gnt and rvalid asserted in the same cycle.
  - Response: bus fields match exactly; mem_rvalid 1 cycle later; back in ARB_IDLE that cycle.
- Flush during fetch:
  - Stimulus: IF owner in ARB_WAIT; flush_if pulse; then bus_rvalid with data 0x1234.
  - Response: no if_rvalid; the next fetch is issued from ARB_IDLE afterwards.
- Timeout:
  - Stimulus: MAX_WAIT=8; bus_gnt never asserted on a MEM load.
  - Response: bus_req drops after 8 cycles; mem_rvalid=1 with rdata=0; bus_timeout=1 and stays 1 until rst.
- Reset mid-WAIT:
  - Stimulus: rst for 1 cycle during ARB_WAIT.
  - Response: all outputs 0 the next cycle; a subsequent tie is won by MEM.
